// File: rtl/stw_pkg.sv
// stw_pkg -- shared definitions for the stopwatch control block.
//   stw_state_t    : control FSM state encoding (IDLE=00, RUN=01, PAUSE=10;
//                    11 is illegal and recovers to IDLE)
//   STW_CLR_ACTIVE : active level of the downstream counter clear
package stw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } stw_state_t;

    localparam logic STW_CLR_ACTIVE = 1'b0;

endpackage

// File: rtl/stw_edge_det.sv
// stw_edge_det -- rising-edge detector for one front-panel switch.
// Optional macro STW_CTRL_SYNC_EN inserts a 2-flop synchronizer ahead of the
// detector (adds 2 cycles of latency).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   sw   : raw switch level, active-high
//   rise : one-cycle pulse per 0->1 transition of the (synchronized) switch
module stw_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic rise
);

    logic level;
    logic prev;

`ifdef STW_CTRL_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], sw};
        end
    end

    assign level = sync[1];
`else
    assign level = sw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    // Combinational pulse so the FSM reacts on the same edge that first
    // samples the switch high.
    assign rise = level & ~prev;

endmodule

// File: rtl/stw_control.sv
// stw_control -- stopwatch run/clear control for the digital clock.
// SW_F1 toggles run/pause; SW_F2 clears a paused or idle stopwatch.
// Optional macro STW_CTRL_SYNC_EN: synchronize both switches (see stw_edge_det).
// Ports:
//   CLK       : system clock
//   RST       : asynchronous active-high reset
//   SW_F1     : start/stop switch level, rising edge is the event
//   SW_F2     : clear switch level, rising edge is the event
//   STW_ON    : registered count enable, high exactly in RUN
//   STW_RST_N : registered active-low clear, low one cycle per accepted clear
//               and held low throughout reset
module stw_control
    import stw_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic SW_F1,
    input  logic SW_F2,
    output logic STW_ON,
    output logic STW_RST_N
);

    logic       f1_rise;
    logic       f2_rise;
    stw_state_t state;
    stw_state_t state_next;
    logic       clr;
    logic       on_r;
    logic       rst_n_r;

    stw_edge_det u_f1 (
        .clk  (CLK),
        .rst  (RST),
        .sw   (SW_F1),
        .rise (f1_rise)
    );

    stw_edge_det u_f2 (
        .clk  (CLK),
        .rst  (RST),
        .sw   (SW_F2),
        .rise (f2_rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // F2 takes priority over F1 when stopped; F2 is ignored while running,
    // so F1 alone decides the RUN transition.
    always_comb begin
        state_next = state;
        clr        = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (f2_rise) begin
                    state_next = IDLE;
                    clr        = 1'b1;
                end else if (f1_rise) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (f1_rise) begin
                    state_next = PAUSE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change on
    // the same edge as the state itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            on_r    <= 1'b0;
            rst_n_r <= STW_CLR_ACTIVE;
        end else begin
            on_r    <= (state_next == RUN);
            rst_n_r <= clr ? STW_CLR_ACTIVE : ~STW_CLR_ACTIVE;
        end
    end

    assign STW_ON    = on_r;
    assign STW_RST_N = rst_n_r;

endmodule

// File: tb/tb_stw_control.sv
// tb_stw_control -- self-checking bench for stw_control (default build).
// Directed sequence followed by randomized switch activity and random
// asynchronous resets, checked against a behavioural model that tracks only
// whether the stopwatch is running.
module tb_stw_control;

    logic clk;
    logic rst;
    logic sw_f1;
    logic sw_f2;
    logic stw_on;
    logic stw_rst_n;

    int n_chk;
    int n_pass;

    // Behavioural model state
    bit m_running;
    bit m_prev1;
    bit m_prev2;
    bit m_rst_n;

    stw_control dut (
        .CLK       (clk),
        .RST       (rst),
        .SW_F1     (sw_f1),
        .SW_F2     (sw_f2),
        .STW_ON    (stw_on),
        .STW_RST_N (stw_rst_n)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_running = 1'b0;
        m_prev1   = 1'b0;
        m_prev2   = 1'b0;
        m_rst_n   = 1'b0;
    endtask

    // One clock edge: the model sees the switch levels present at the edge.
    task automatic step(input string tag);
        bit f1ev;
        bit f2ev;
        bit clr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            f1ev    = sw_f1 && !m_prev1;
            f2ev    = sw_f2 && !m_prev2;
            m_prev1 = sw_f1;
            m_prev2 = sw_f2;
            clr     = f2ev && !m_running;
            if (clr) m_running = 1'b0;
            else if (f1ev) m_running = !m_running;
            m_rst_n = !clr;
        end
        #10;
        check({tag, ".on"}, stw_on, m_running);
        check({tag, ".rst_n"}, stw_rst_n, m_rst_n);
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        #5;
        model_reset();
        check({tag, ".on"}, stw_on, 1'b0);
        check({tag, ".rst_n"}, stw_rst_n, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        sw_f1  = 1'b0;
        sw_f2  = 1'b0;
        model_reset();

        // Reset held
        step("reset0");
        step("reset1");

        // Release with F1 pressed: first edge starts the stopwatch
        rst   = 1'b0;
        sw_f1 = 1'b1;
        step("start");
        sw_f1 = 1'b0;
        repeat (4) step("running");

        // Pause
        sw_f1 = 1'b1;
        step("pause");
        sw_f1 = 1'b0;
        repeat (4) step("paused");

        // Clear while paused
        sw_f2 = 1'b1;
        step("clr_pause");
        sw_f2 = 1'b0;
        step("clr_release");

        // Clear ignored while running
        sw_f1 = 1'b1; step("run2");
        sw_f1 = 1'b0; step("run2_hold");
        sw_f2 = 1'b1; step("clr_in_run");
        sw_f2 = 1'b0; step("clr_in_run_after");

        // Simultaneous in PAUSE -> IDLE with clear
        sw_f1 = 1'b1; step("pause2");
        sw_f1 = 1'b0; step("pause2_hold");
        sw_f1 = 1'b1; sw_f2 = 1'b1; step("both_pause");
        sw_f1 = 1'b0; sw_f2 = 1'b0; step("both_pause_after");

        // Simultaneous in RUN -> PAUSE, no clear
        sw_f1 = 1'b1; step("run3");
        sw_f1 = 1'b0; step("run3_hold");
        sw_f1 = 1'b1; sw_f2 = 1'b1; step("both_run");
        sw_f1 = 1'b0; sw_f2 = 1'b0; step("both_run_after");

        // Back to IDLE, then F1 held for 5 cycles gives a single toggle
        sw_f2 = 1'b1; step("to_idle");
        sw_f2 = 1'b0; step("idle");
        sw_f1 = 1'b1;
        repeat (5) step("held_f1");
        sw_f1 = 1'b0;
        step("held_f1_release");

        // Asynchronous reset mid-run, F1 held across the release
        async_reset_check("rst_midrun");
        sw_f1 = 1'b1;
        step("rst_hold0");
        step("rst_hold1");
        rst = 1'b0;
        step("rst_release_f1");
        sw_f1 = 1'b0;
        step("rst_release_after");

        // Randomized activity
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset_check("rand_rst");
                step("rand_rst_hold");
                rst = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) sw_f1 = ~sw_f1;
            if ($urandom_range(0, 3) == 0) sw_f2 = ~sw_f2;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
